// File: rtl/gnrc_stream_wrr_mux.sv
// rtl/gnrc_stream_wrr_mux.sv - weighted round-robin packet scheduler and stream multiplexer
// Grants whole packets; each source gets up to weight_i[k] packets per turn.
module gnrc_stream_wrr_mux #(
   parameter int  N     = 2,
   parameter type DTYPE = logic,
   parameter int  WW    = 4,
   parameter int  AW    = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 flush_i,
   input  logic [N-1:0][WW-1:0] weight_i,
   input  DTYPE [N-1:0]         data_i,
   input  logic [N-1:0]         valid_i,
   input  logic [N-1:0]         last_i,
   output logic [N-1:0]         ready_o,
   output DTYPE                 data_o,
   output logic                 valid_o,
   output logic                 last_o,
   output logic [AW-1:0]        id_o,
   input  logic                 ready_i
);

   logic [AW-1:0] ptr;
   logic [WW-1:0] rem;
   logic          lock;

   logic [AW-1:0] sel;
   logic [AW-1:0] cand;
   logic          sel_vld;
   logic          new_turn;

   // Selection never looks at ready_i, so valid/data/id have no path from it.
   always_comb begin
      sel      = ptr;
      cand     = ptr;
      sel_vld  = 1'b0;
      new_turn = 1'b0;
      if (lock) begin
         sel_vld = valid_i[ptr];
      end else if (valid_i[ptr] && (rem != '0)) begin
         sel_vld = 1'b1;
      end else begin
         for (int i = 1; i <= N; i++) begin
            cand = AW'((int'(ptr) + i) % N);
            if (!sel_vld && valid_i[cand] && (weight_i[cand] != '0)) begin
               sel      = cand;
               sel_vld  = 1'b1;
               new_turn = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ready_o = '0;
      valid_o = sel_vld;
      data_o  = sel_vld ? data_i[sel] : '0;
      last_o  = sel_vld & last_i[sel];
      id_o    = sel_vld ? sel : '0;
      if (sel_vld) ready_o[sel] = ready_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr  <= AW'(N - 1);
         rem  <= '0;
         lock <= 1'b0;
      end else if (flush_i) begin
         ptr  <= AW'(N - 1);
         rem  <= '0;
         lock <= 1'b0;
      end else if (sel_vld && ready_i) begin
         // Weight is sampled only here, so mid-turn changes wait for the next turn.
         if (new_turn) begin
            ptr <= sel;
            rem <= weight_i[sel] - WW'(last_i[sel]);
         end else if (last_i[sel]) begin
            rem <= rem - 1'b1;
         end
         lock <= ~last_i[sel];
      end
   end

endmodule

// File: tb/tb_gnrc_stream_wrr_mux.sv
// tb/tb_gnrc_stream_wrr_mux.sv - directed self-checking bench for gnrc_stream_wrr_mux
module tb_gnrc_stream_wrr_mux;

   localparam int N  = 3;
   localparam int WW = 4;
   localparam int AW = 2;

   logic                 clk;
   logic                 rst_ni;
   logic                 flush_i;
   logic [N-1:0][WW-1:0] weight_i;
   logic [N-1:0][7:0]    data_i;
   logic [N-1:0]         valid_i;
   logic [N-1:0]         last_i;
   logic [N-1:0]         ready_o;
   logic [7:0]           data_o;
   logic                 valid_o;
   logic                 last_o;
   logic [AW-1:0]        id_o;
   logic                 ready_i;

   int n_checks = 0;
   int n_fails  = 0;

   gnrc_stream_wrr_mux #(
      .N    (N),
      .DTYPE(logic [7:0]),
      .WW   (WW)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .weight_i(weight_i),
      .data_i  (data_i),
      .valid_i (valid_i),
      .last_i  (last_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .valid_o (valid_o),
      .last_o  (last_o),
      .id_o    (id_o),
      .ready_i (ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [2:0] v, input logic [2:0] l, input logic r);
      valid_i = v;
      last_i  = l;
      ready_i = r;
      #1;
   endtask

   task automatic do_flush();
      set_in(3'b000, 3'b000, 1'b1);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
   endtask

   int exp1[9] = '{0, 1, 1, 2, 2, 2, 0, 1, 1};
   int exp4[8] = '{0, 2, 2, 2, 0, 2, 0, 2};
   int exp5[6] = '{2, 0, 2, 2, 2, 0};
   logic [2:0] vld5[6] = '{3'b100, 3'b011, 3'b100, 3'b101, 3'b101, 3'b101};

   initial begin
      rst_ni   = 1'b0;
      flush_i  = 1'b0;
      weight_i = '0;
      data_i   = {8'hA2, 8'hA1, 8'hA0};
      valid_i  = '0;
      last_i   = '0;
      ready_i  = 1'b0;
      #3;
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_ready", 32'(ready_o), 32'd0);
      check("rst_data",  32'(data_o),  32'd0);
      check("rst_id",    32'(id_o),    32'd0);
      check("rst_last",  32'(last_o),  32'd0);
      cyc();
      rst_ni = 1'b1;
      cyc();

      // Weighted order with single-beat packets
      weight_i = {4'd3, 4'd2, 4'd1};
      set_in(3'b111, 3'b111, 1'b1);
      for (int i = 0; i < 9; i++) begin
         check($sformatf("t1_valid%0d", i), 32'(valid_o), 32'd1);
         check($sformatf("t1_id%0d", i),    32'(id_o),    32'(exp1[i]));
         check($sformatf("t1_data%0d", i),  32'(data_o),  32'(8'hA0 + exp1[i]));
         cyc();
      end

      // Multi-beat lock, including a mid-packet bubble from the owner
      do_flush();
      weight_i = {4'd1, 4'd1, 4'd1};
      set_in(3'b001, 3'b000, 1'b1);
      check("t2_id0",  32'(id_o),    32'd0);
      check("t2_rdy0", 32'(ready_o), 32'b001);
      cyc();
      set_in(3'b011, 3'b010, 1'b1);
      check("t2_id1",  32'(id_o),    32'd0);
      check("t2_rdy1", 32'(ready_o), 32'b001);
      cyc();
      set_in(3'b010, 3'b010, 1'b1);
      check("t2_bubble_valid", 32'(valid_o), 32'd0);
      check("t2_bubble_rdy",   32'(ready_o), 32'b000);
      cyc();
      set_in(3'b011, 3'b011, 1'b1);
      check("t2_id3",   32'(id_o),    32'd0);
      check("t2_last3", 32'(last_o),  32'd1);
      check("t2_rdy3",  32'(ready_o), 32'b001);
      cyc();
      set_in(3'b010, 3'b010, 1'b1);
      check("t2_id4",  32'(id_o),    32'd1);
      check("t2_rdy4", 32'(ready_o), 32'b010);
      cyc();

      // Backpressure holds the beat stable
      do_flush();
      data_i[2] = 8'hC0;
      set_in(3'b100, 3'b000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t3_valid%0d", i), 32'(valid_o), 32'd1);
         check($sformatf("t3_rdy%0d", i),   32'(ready_o), 32'b000);
         check($sformatf("t3_id%0d", i),    32'(id_o),    32'd2);
         check($sformatf("t3_data%0d", i),  32'(data_o),  32'hC0);
         check($sformatf("t3_last%0d", i),  32'(last_o),  32'd0);
         cyc();
      end
      set_in(3'b100, 3'b000, 1'b1);
      check("t3_rdy_go", 32'(ready_o), 32'b100);
      cyc();
      data_i[2] = 8'hC1;
      set_in(3'b101, 3'b100, 1'b1);
      check("t3_beat2_id",   32'(id_o),   32'd2);
      check("t3_beat2_data", 32'(data_o), 32'hC1);
      check("t3_beat2_last", 32'(last_o), 32'd1);
      cyc();
      set_in(3'b001, 3'b001, 1'b1);
      check("t3_next_id", 32'(id_o), 32'd0);
      cyc();
      data_i[2] = 8'hA2;

      // Disabled port and mid-turn weight change
      do_flush();
      weight_i = {4'd3, 4'd0, 4'd1};
      set_in(3'b111, 3'b111, 1'b1);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            weight_i[2] = 4'd1;
            #1;
         end
         check($sformatf("t4_id%0d", i), 32'(id_o), 32'(exp4[i]));
         cyc();
      end

      // Forfeit of remaining quota
      do_flush();
      weight_i = {4'd3, 4'd1, 4'd1};
      for (int i = 0; i < 6; i++) begin
         set_in(vld5[i], 3'b111, 1'b1);
         check($sformatf("t5_id%0d", i), 32'(id_o), 32'(exp5[i]));
         cyc();
      end

      // Flush mid-turn, then reset mid-packet
      do_flush();
      weight_i = {4'd1, 4'd2, 4'd1};
      set_in(3'b111, 3'b111, 1'b1);
      check("t6_id0", 32'(id_o), 32'd0);
      cyc();
      check("t6_id1", 32'(id_o), 32'd1);
      cyc();
      flush_i = 1'b1;
      #1;
      check("t6_id_flush", 32'(id_o), 32'd1);
      cyc();
      flush_i = 1'b0;
      #1;
      check("t6_id_after_flush", 32'(id_o), 32'd0);
      cyc();
      set_in(3'b010, 3'b000, 1'b1);
      check("t6_pkt_id", 32'(id_o), 32'd1);
      cyc();
      set_in(3'b000, 3'b000, 1'b1);
      rst_ni = 1'b0;
      #1;
      check("t6_rst_valid", 32'(valid_o), 32'd0);
      check("t6_rst_ready", 32'(ready_o), 32'd0);
      check("t6_rst_data",  32'(data_o),  32'd0);
      cyc();
      rst_ni = 1'b1;
      set_in(3'b111, 3'b111, 1'b1);
      check("t6_post_rst_valid", 32'(valid_o), 32'd1);
      check("t6_post_rst_id",    32'(id_o),    32'd0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/gnrc_stream_wrr_mux.md
# gnrc_stream_wrr_mux

Weighted round-robin packet scheduler and multiplexer. It shares one AXI-stream-like manager port between N subordinate stream sources. Each source receives a turn of up to `weight_i[k]` whole packets before the grant advances. The grant is locked from the first beat to the last beat of a packet, and the per-port weights are runtime configuration from a CSR block.

## Interface
- `N`, 2: number of subordinate ports, ≥1.
- `DTYPE`, logic: payload type of each port.
- `WW`, 4: weight width; a turn is at most 2^WW−1 packets.
- `AW`, (N>1)?$clog2(N):1: id width. Auto-derived; do not override.

- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous reset, active low.
- `flush_i`  in  1  synchronous scheduler clear, see Operation.
- `weight_i`  in  [N-1:0][WW-1:0]  packets per turn for each port; 0 disables the port.
- `data_i`  in  DTYPE [N-1:0]  input payload.
- `valid_i`  in  [N-1:0]  input valid.
- `last_i`  in  [N-1:0]  last beat of the packet.
- `ready_o`  out  [N-1:0]  input ready, one-hot or zero.
- `data_o`  out  DTYPE  output payload.
- `valid_o`  out  1  output valid.
- `last_o`  out  1  output last.
- `id_o`  out  AW  index of the selected source.
- `ready_i`  in  1  output ready.

## Operation
**State registers**
- `ptr` (AW): current turn owner. Reset value N−1.
- `rem` (WW): packets remaining in the turn. Reset value 0.
- `lock` (1): mid-packet flag, forming two states, IDLE (lock=0) and BUSY (lock=1). Reset value IDLE.

**Eligibility**
- Port k is eligible when `valid_i[k]` is high and `weight_i[k]` ≠ 0.

**Selection `sel` in IDLE**
- If `valid_i[ptr]` is high and `rem` ≠ 0, then sel = ptr; the turn continues.
- Otherwise, search cyclically from ptr+1 through ptr inclusive, wrapping N−1→0. The first eligible port is sel, and that is a new turn.
- If no port is eligible, valid_o = 0.

**Selection in BUSY**
- sel = ptr, and valid_o = valid_i[ptr].

**Outputs (combinational, from sel)**
- data_o = data_i[sel], last_o = last_i[sel], id_o = sel.
- ready_o[sel] = ready_i & valid_o; all other bits are 0.
- When valid_o = 0: data_o = '0, last_o = 0, id_o = 0, ready_o = 0.

**Register updates on a transfer (valid_o & ready_i)**
- On the first beat of a new turn: ptr ← sel, and rem ← weight_i[sel] − (last_i[sel] ? 1 : 0). The weight is sampled only at turn start; weight changes mid-turn take effect at the next turn.
- On a beat with last_o = 0: lock ← 1.
- On a beat with last_o = 1: lock ← 0, and rem decrements. This covers a single-beat packet in IDLE.

**Turn boundaries**
- When rem reaches 0, the turn ends and the next selection searches from ptr+1.
- If the owner is not valid in IDLE while rem ≠ 0, the remaining quota is forfeited and the search starts from ptr+1. rem is reloaded when a new port wins.

**flush_i**
- flush_i sets ptr ← N−1, rem ← 0, lock ← 0 on the next edge and overrides any transfer update in the same cycle.
- Asserting flush_i mid-packet breaks packet framing. This is the caller's responsibility.

**Degenerate case N = 1**
- Port 0 is always selected when eligible; rem and ptr are don't-care.

## Timing
- Zero-latency datapath: data_i, valid_i, last_i reach data_o, valid_o, last_o, id_o in the same cycle.
- ready_i reaches ready_o combinationally.
- There is no combinational path from ready_i to valid_o, data_o or id_o.
- Once valid_o is high with ready_i low, sel, data_o and id_o stay stable until the transfer completes. This relies on sources obeying AXI valid-hold; the scheduler state does not change without a transfer.
- Back-to-back packets from different ports have no bubble: the cycle after a last beat may transfer the new owner's first beat.
- Asynchronous reset deasserts all registers immediately. With valid_i = 0, all outputs read 0.

## Test plan
1. **Single-beat packets, weighted order.** N=3, weights {1,2,3}, all ports valid, every beat last, ready_i=1 → id_o sequence 0,1,1,2,2,2,0,1,… with no idle cycles.
2. **Multi-beat lock.** Port0 sends a 4-beat packet; port1 valid from cycle 1 → id_o = 0 for 4 beats, last_o high on beat 4, id_o = 1 in the next cycle, ready_o[1] = 0 throughout the port0 packet.
3. **Backpressure.** ready_i = 0 for 3 cycles with valid_o high → ready_o = 0, and data_o, id_o, last_o stay constant. Then ready_i = 1 → exactly one beat transfers.
4. **Disabled port and mid-turn weight change.** weights {1,0,3}, all valid → sequence 0,2,2,2,0,…, port1 never granted. Changing w2 to 1 during port2's turn leaves that turn at 3 packets; the next port2 turn is 1 packet.
5. **Forfeit.** Port2 owns the turn with rem = 2 and drops valid → next grant goes to port0; port2 has to win a new turn to get its full weight back.
6. **Flush and reset.** flush_i pulsed while port1 has rem = 1 → next grant is port0. rst_ni pulsed low mid-packet → lock = 0, valid_o = 0 while inputs are idle, and the first grant after release is port0.
